// File: rtl/ahb_mtx_l1_pkg.sv
// ---------------------------------------------------------------------------
// ahb_mtx_l1_pkg
// Shared AHB matrix definitions: HTRANS / HBURST / HRESP encodings and the
// packed address/control record carried through the matrix input stages.
// ---------------------------------------------------------------------------
package ahb_mtx_l1_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_WRAP4  = 3'b010,
      HBURST_INCR4  = 3'b011,
      HBURST_WRAP8  = 3'b100,
      HBURST_INCR8  = 3'b101,
      HBURST_WRAP16 = 3'b110,
      HBURST_INCR16 = 3'b111
   } hburst_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01,
      HRESP_RETRY = 2'b10,
      HRESP_SPLIT = 2'b11
   } hresp_e;

   // One address-phase worth of master control (47 bits).
   typedef struct packed {
      logic        sel;
      logic [31:0] addr;
      logic [1:0]  trans;
      logic        write;
      logic [2:0]  size;
      logic [2:0]  burst;
      logic [3:0]  prot;
      logic        mastlock;
   } ahb_ctrl_t;

   // NONSEQ and SEQ both have trans[1] set; IDLE and BUSY do not.
   function automatic logic is_real_trans(input logic [1:0] trans);
      return trans[1];
   endfunction

endpackage

// File: rtl/ahb_mtx_l1_in_hold.sv
// ---------------------------------------------------------------------------
// ahb_mtx_l1_in_hold
// Holding register for one matrix input port. Captures a master address
// phase that the output stage could not take, and presents it again later.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   load          : capture ctrl_in and mark pending (wins over clear)
//   clear         : drop the pending transfer
//   ctrl_in       : live master address/control
//   pend_tran     : a captured transfer is waiting
//   ctrl_held     : captured transfer as it must be re-presented
// ---------------------------------------------------------------------------
module ahb_mtx_l1_in_hold
   import ahb_mtx_l1_pkg::*;
(
   input  logic      HCLK,
   input  logic      HRESETn,
   input  logic      load,
   input  logic      clear,
   input  ahb_ctrl_t ctrl_in,
   output logic      pend_tran,
   output ahb_ctrl_t ctrl_held
);

   ahb_ctrl_t hold_q;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         pend_tran <= 1'b0;
         hold_q    <= '0;
      end else if (load) begin
         pend_tran <= 1'b1;
         hold_q    <= ctrl_in;
      end else if (clear) begin
         pend_tran <= 1'b0;
      end
   end

   // A held SEQ beat may reach the slave after another master's transfer,
   // so it is re-issued as the start of an undefined-length burst.
   always_comb begin
      ctrl_held = hold_q;
      if (hold_q.trans == HTRANS_SEQ) begin
         ctrl_held.trans = HTRANS_NONSEQ;
         ctrl_held.burst = HBURST_INCR;
      end
   end

endmodule

// File: rtl/ahb_mtx_l1_in_stage.sv
// ---------------------------------------------------------------------------
// ahb_mtx_l1_in_stage
// AHB matrix input stage: forwards a master's address phase to the decoder
// and output arbiters, holding it when the output stage cannot accept it.
//   HCLK, HRESETn          : clock, asynchronous active-low reset
//   H*S (sel..mastlock)    : master address/control, HREADYS master ready
//   H*M (sel..mastlock)    : address/control toward decoder / arbiters
//   active_trans           : request to the output-stage arbiter
//   addr_in_phase          : output stage has this port in address phase
//   data_in_phase          : output stage has this port in data phase
//   HREADYM, HRESPM        : ready/response from owning output stage
//   HREADYOUTS, HRESPS     : ready/response back to the master
// ---------------------------------------------------------------------------
module ahb_mtx_l1_in_stage
   import ahb_mtx_l1_pkg::*;
(
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSELS,
   input  logic [31:0] HADDRS,
   input  logic [1:0]  HTRANSS,
   input  logic        HWRITES,
   input  logic [2:0]  HSIZES,
   input  logic [2:0]  HBURSTS,
   input  logic [3:0]  HPROTS,
   input  logic        HMASTLOCKS,
   input  logic        HREADYS,
   output logic        HSELM,
   output logic [31:0] HADDRM,
   output logic [1:0]  HTRANSM,
   output logic        HWRITEM,
   output logic [2:0]  HSIZEM,
   output logic [2:0]  HBURSTM,
   output logic [3:0]  HPROTM,
   output logic        HMASTLOCKM,
   output logic        active_trans,
   input  logic        addr_in_phase,
   input  logic        data_in_phase,
   input  logic        HREADYM,
   input  logic [1:0]  HRESPM,
   output logic        HREADYOUTS,
   output logic [1:0]  HRESPS
);

   ahb_ctrl_t s_ctrl;
   ahb_ctrl_t held_ctrl;
   ahb_ctrl_t m_ctrl;
   logic      new_tran;
   logic      load;
   logic      clear;
   logic      discard;
   logic      pend_tran;
   logic      err_q;

   assign s_ctrl = {HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS};

   assign new_tran = HSELS & is_real_trans(HTRANSS) & HREADYS;
   assign load     = new_tran & (~addr_in_phase | ~HREADYM);

   // First cycle of a two-cycle ERROR seen; if the master answers with IDLE
   // on the next cycle, the waiting transfer is abandoned.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         err_q <= 1'b0;
      end else begin
         err_q <= data_in_phase & (HRESPM == HRESP_ERROR) & ~HREADYM;
      end
   end

   assign discard = err_q & (HTRANSS == HTRANS_IDLE) & HREADYS;
   assign clear   = (addr_in_phase & HREADYM) | discard;

   ahb_mtx_l1_in_hold u_hold (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .load      (load),
      .clear     (clear),
      .ctrl_in   (s_ctrl),
      .pend_tran (pend_tran),
      .ctrl_held (held_ctrl)
   );

   // Held copy (including HMASTLOCK) owns the M side while pending.
   assign m_ctrl = pend_tran ? held_ctrl : s_ctrl;
   assign {HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM} = m_ctrl;

   // Reset forces the master-facing handshake to its idle values even if
   // the output stage still reports a data phase.
   assign active_trans = HRESETn & (pend_tran | new_tran);
   assign HREADYOUTS   = ~HRESETn | (~pend_tran & (~data_in_phase | HREADYM));
   assign HRESPS       = (HRESETn & data_in_phase) ? HRESPM : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_mtx_l1_in_stage.sv
module tb_ahb_mtx_l1_in_stage;
   import ahb_mtx_l1_pkg::*;

   logic        HCLK;
   logic        HRESETn;
   logic        HSELS;
   logic [31:0] HADDRS;
   logic [1:0]  HTRANSS;
   logic        HWRITES;
   logic [2:0]  HSIZES;
   logic [2:0]  HBURSTS;
   logic [3:0]  HPROTS;
   logic        HMASTLOCKS;
   logic        HREADYS;
   logic        HSELM;
   logic [31:0] HADDRM;
   logic [1:0]  HTRANSM;
   logic        HWRITEM;
   logic [2:0]  HSIZEM;
   logic [2:0]  HBURSTM;
   logic [3:0]  HPROTM;
   logic        HMASTLOCKM;
   logic        active_trans;
   logic        addr_in_phase;
   logic        data_in_phase;
   logic        HREADYM;
   logic [1:0]  HRESPM;
   logic        HREADYOUTS;
   logic [1:0]  HRESPS;

   int checks = 0;
   int errors = 0;

   ahb_mtx_l1_in_stage dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS), .HWRITES(HWRITES),
      .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS),
      .HREADYS(HREADYS),
      .HSELM(HSELM), .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM),
      .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTLOCKM(HMASTLOCKM),
      .active_trans(active_trans), .addr_in_phase(addr_in_phase),
      .data_in_phase(data_in_phase), .HREADYM(HREADYM), .HRESPM(HRESPM),
      .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   // The pending transfer is a queue holding at most one address phase.
   ahb_ctrl_t held_q[$];
   bit        err_prev;

   function automatic ahb_ctrl_t s_inputs();
      return {HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS};
   endfunction

   function automatic ahb_ctrl_t dut_m();
      return {HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM};
   endfunction

   function automatic ahb_ctrl_t exp_m();
      ahb_ctrl_t r;
      if (HRESETn && held_q.size() > 0) begin
         r = held_q[0];
         if (r.trans == 2'b11) begin
            r.trans = 2'b10;
            r.burst = 3'b001;
         end
      end else begin
         r = s_inputs();
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      bit pend, nt, e_rdy, e_act;
      logic [1:0] e_resp;
      pend  = HRESETn && held_q.size() > 0;
      nt    = HSELS && HTRANSS[1] && HREADYS;
      e_act = HRESETn && (pend || nt);
      if (!HRESETn)           e_rdy = 1'b1;
      else if (pend)          e_rdy = 1'b0;
      else if (data_in_phase) e_rdy = HREADYM;
      else                    e_rdy = 1'b1;
      e_resp = (HRESETn && data_in_phase) ? HRESPM : 2'b00;
      chk({tag, ".m_side"}, 64'(dut_m()), 64'(exp_m()));
      chk({tag, ".hreadyouts"}, 64'(HREADYOUTS), 64'(e_rdy));
      chk({tag, ".hresps"}, 64'(HRESPS), 64'(e_resp));
      chk({tag, ".active_trans"}, 64'(active_trans), 64'(e_act));
   endtask

   task automatic model_update();
      ahb_ctrl_t s;
      bit nt, disc;
      s  = s_inputs();
      nt = s.sel && s.trans[1] && HREADYS;
      if (!HRESETn) begin
         held_q.delete();
         err_prev = 1'b0;
         return;
      end
      disc = err_prev && (HTRANSS == 2'b00) && HREADYS;
      if (nt && (!addr_in_phase || !HREADYM)) begin
         held_q.delete();
         held_q.push_back(s);
      end else if (addr_in_phase && HREADYM) begin
         held_q.delete();
      end else if (disc) begin
         held_q.delete();
      end
      err_prev = data_in_phase && (HRESPM == 2'b01) && !HREADYM;
   endtask

   task automatic advance();
      @(posedge HCLK);
      model_update();
      @(negedge HCLK);
   endtask

   task automatic drive_s(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                          input logic [2:0] burst, input logic rdys);
      HSELS = sel; HADDRS = addr; HTRANSS = trans; HBURSTS = burst; HREADYS = rdys;
      HWRITES = 1'b1; HSIZES = 3'd2; HPROTS = 4'h3; HMASTLOCKS = 1'b0;
   endtask

   task automatic drive_m(input logic aip, input logic dip, input logic rdym, input logic [1:0] resp);
      addr_in_phase = aip; data_in_phase = dip; HREADYM = rdym; HRESPM = resp;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        sel;
      logic [31:0] addr;
      logic [1:0]  trans;
      logic [2:0]  burst;
      logic        rdys, aip, dip, rdym;
      logic [1:0]  resp;
      logic        e_rdy;
      logic [1:0]  e_resp;
      logic [31:0] e_addr;
      logic [1:0]  e_trans;
      logic [2:0]  e_burst;
      logic        e_act;
   } vec_t;

   function automatic vec_t mk(
      input logic sel, input logic [31:0] addr, input logic [1:0] trans, input logic [2:0] burst,
      input logic rdys, input logic aip, input logic dip, input logic rdym, input logic [1:0] resp,
      input logic e_rdy, input logic [1:0] e_resp, input logic [31:0] e_addr,
      input logic [1:0] e_trans, input logic [2:0] e_burst, input logic e_act);
      vec_t v;
      v.sel = sel; v.addr = addr; v.trans = trans; v.burst = burst;
      v.rdys = rdys; v.aip = aip; v.dip = dip; v.rdym = rdym; v.resp = resp;
      v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_addr = e_addr;
      v.e_trans = e_trans; v.e_burst = e_burst; v.e_act = e_act;
      return v;
   endfunction

   vec_t vt[14];

   initial begin
      // accepted immediately
      vt[0]  = mk(1, 32'h2000_0000, 2'b10, 3'd0, 1, 1, 0, 1, 2'b00,  1, 2'b00, 32'h2000_0000, 2'b10, 3'd0, 1);
      // blocked NONSEQ, previous data phase completes
      vt[1]  = mk(1, 32'h4000_0010, 2'b10, 3'd0, 1, 0, 1, 1, 2'b00,  1, 2'b00, 32'h4000_0010, 2'b10, 3'd0, 1);
      vt[2]  = mk(0, 32'h0,         2'b00, 3'd0, 0, 0, 0, 1, 2'b00,  0, 2'b00, 32'h4000_0010, 2'b10, 3'd0, 1);
      vt[3]  = mk(0, 32'h0,         2'b00, 3'd0, 0, 0, 0, 1, 2'b00,  0, 2'b00, 32'h4000_0010, 2'b10, 3'd0, 1);
      vt[4]  = mk(0, 32'h0,         2'b00, 3'd0, 0, 0, 0, 1, 2'b00,  0, 2'b00, 32'h4000_0010, 2'b10, 3'd0, 1);
      // granted
      vt[5]  = mk(0, 32'h0,         2'b00, 3'd0, 0, 1, 0, 1, 2'b00,  0, 2'b00, 32'h4000_0010, 2'b10, 3'd0, 1);
      vt[6]  = mk(0, 32'h0,         2'b00, 3'd0, 0, 0, 1, 0, 2'b00,  0, 2'b00, 32'h0,         2'b00, 3'd0, 0);
      vt[7]  = mk(0, 32'h0,         2'b00, 3'd0, 0, 0, 1, 1, 2'b00,  1, 2'b00, 32'h0,         2'b00, 3'd0, 0);
      // SEQ beat of INCR4 blocked
      vt[8]  = mk(1, 32'h6000_0004, 2'b11, 3'd3, 1, 0, 0, 1, 2'b00,  1, 2'b00, 32'h6000_0004, 2'b11, 3'd3, 1);
      vt[9]  = mk(0, 32'h0,         2'b00, 3'd0, 0, 0, 0, 1, 2'b00,  0, 2'b00, 32'h6000_0004, 2'b10, 3'd1, 1);
      vt[10] = mk(0, 32'h0,         2'b00, 3'd0, 0, 1, 0, 1, 2'b00,  0, 2'b00, 32'h6000_0004, 2'b10, 3'd1, 1);
      // data-phase wait states
      vt[11] = mk(0, 32'h0,         2'b00, 3'd0, 0, 0, 1, 0, 2'b00,  0, 2'b00, 32'h0,         2'b00, 3'd0, 0);
      vt[12] = mk(0, 32'h0,         2'b00, 3'd0, 0, 0, 1, 0, 2'b00,  0, 2'b00, 32'h0,         2'b00, 3'd0, 0);
      vt[13] = mk(0, 32'h0,         2'b00, 3'd0, 0, 0, 1, 1, 2'b00,  1, 2'b00, 32'h0,         2'b00, 3'd0, 0);
   end

   // ---------------- test sequence ----------------
   initial begin
      err_prev = 1'b0;
      HRESETn  = 1'b0;
      // Reset with a live request and an ERROR data phase on the inputs.
      drive_s(1, 32'h1234_5678, 2'b10, 3'd0, 1);
      drive_m(0, 1, 0, 2'b01);
      @(negedge HCLK);
      #1;
      chk("reset.hreadyouts", 64'(HREADYOUTS), 64'd1);
      chk("reset.hresps", 64'(HRESPS), 64'd0);
      chk("reset.active_trans", 64'(active_trans), 64'd0);
      chk("reset.haddrm_pass", 64'(HADDRM), 64'h1234_5678);
      check_all("reset");
      advance();
      HRESETn = 1'b1;

      // Directed table
      for (int i = 0; i < 14; i++) begin
         drive_s(vt[i].sel, vt[i].addr, vt[i].trans, vt[i].burst, vt[i].rdys);
         drive_m(vt[i].aip, vt[i].dip, vt[i].rdym, vt[i].resp);
         #1;
         chk($sformatf("vec%0d.hreadyouts", i), 64'(HREADYOUTS), 64'(vt[i].e_rdy));
         chk($sformatf("vec%0d.hresps", i), 64'(HRESPS), 64'(vt[i].e_resp));
         chk($sformatf("vec%0d.haddrm", i), 64'(HADDRM), 64'(vt[i].e_addr));
         chk($sformatf("vec%0d.htransm", i), 64'(HTRANSM), 64'(vt[i].e_trans));
         chk($sformatf("vec%0d.hburstm", i), 64'(HBURSTM), 64'(vt[i].e_burst));
         chk($sformatf("vec%0d.active_trans", i), 64'(active_trans), 64'(vt[i].e_act));
         advance();
      end

      // Two-cycle ERROR with a pending transfer, master then goes IDLE
      drive_s(1, 32'h8000_0000, 2'b10, 3'd0, 1);
      drive_m(0, 0, 1, 2'b00);
      #1; check_all("err.c1"); advance();
      drive_s(0, 32'h0, 2'b00, 3'd0, 0);
      drive_m(0, 1, 0, 2'b01);
      #1;
      chk("err.c2.hresps", 64'(HRESPS), 64'd1);
      chk("err.c2.hreadyouts", 64'(HREADYOUTS), 64'd0);
      chk("err.c2.active_trans", 64'(active_trans), 64'd1);
      check_all("err.c2"); advance();
      drive_s(0, 32'h0, 2'b00, 3'd0, 1);
      drive_m(0, 1, 1, 2'b01);
      #1;
      chk("err.c3.hresps", 64'(HRESPS), 64'd1);
      check_all("err.c3"); advance();
      drive_m(0, 0, 1, 2'b00);
      #1;
      chk("err.c4.active_trans", 64'(active_trans), 64'd0);
      chk("err.c4.hreadyouts", 64'(HREADYOUTS), 64'd1);
      chk("err.c4.htransm", 64'(HTRANSM), 64'd0);
      check_all("err.c4"); advance();

      // Reset while a transfer is pending
      drive_s(1, 32'hA000_0000, 2'b10, 3'd0, 1);
      drive_m(0, 0, 1, 2'b00);
      #1; check_all("rstp.c1"); advance();
      drive_s(0, 32'h0, 2'b00, 3'd0, 0);
      #1;
      chk("rstp.pending_hreadyouts", 64'(HREADYOUTS), 64'd0);
      chk("rstp.pending_haddrm", 64'(HADDRM), 64'hA000_0000);
      #1 HRESETn = 1'b0;
      #1;
      chk("rstp.hreadyouts", 64'(HREADYOUTS), 64'd1);
      chk("rstp.active_trans", 64'(active_trans), 64'd0);
      chk("rstp.haddrm_pass", 64'(HADDRM), 64'h0);
      advance();
      HRESETn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("rstp.after%0d.active_trans", i), 64'(active_trans), 64'd0);
         chk($sformatf("rstp.after%0d.hreadyouts", i), 64'(HREADYOUTS), 64'd1);
         advance();
      end

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         HRESETn = ($urandom_range(0, 49) != 0);
         drive_s(($urandom_range(0, 3) != 0), $urandom, 2'($urandom), 3'($urandom),
                 ($urandom_range(0, 3) != 0));
         HWRITES    = 1'($urandom);
         HSIZES     = 3'($urandom);
         HPROTS     = 4'($urandom);
         HMASTLOCKS = 1'($urandom);
         drive_m(1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00);
         #1;
         check_all($sformatf("rand%0d", i));
         advance();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_mtx_l1_in_stage.md
AHB_MTX_L1_IN_STAGE -- requirements
Module: ahb_mtx_l1_in_stage

Interface
REQ-001 SHALL have HCLK  in  1  AHB clock; all state updates on rising edge.
REQ-002 SHALL have HRESETn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have HSELS in 1, HADDRS in 32, HTRANSS in 2, HWRITES in 1, HSIZES in 3, HBURSTS in 3, HPROTS in 4, HMASTLOCKS in 1: master-side address/control.
REQ-004 SHALL have HREADYS  in  1  master-side bus ready (address sampled only when high).
REQ-005 SHALL have HSELM out 1, HADDRM out 32, HTRANSM out 2, HWRITEM out 1, HSIZEM out 3, HBURSTM out 3, HPROTM out 4, HMASTLOCKM out 1: address/control toward decoder and output arbiters.
REQ-006 SHALL have active_trans  out  1  request qualifier feeding the output-stage arbiter req_portN.
REQ-007 SHALL have addr_in_phase  in  1  output stage has this port selected in address phase.
REQ-008 SHALL have data_in_phase  in  1  output stage has this port in data phase.
REQ-009 SHALL have HREADYM in 1 and HRESPM in 2: ready/response of the output stage currently owning this port.
REQ-010 SHALL have HREADYOUTS out 1 and HRESPS out 2: ready/response back to the master.

Function
REQ-011 SHALL define new_tran = HSELS & HTRANSS[1] & HREADYS (NONSEQ or SEQ only; IDLE/BUSY never captured).
REQ-012 SHALL capture all master address/control into a holding register and set pend_tran=1 when new_tran=1 and (addr_in_phase=0 or HREADYM=0).
REQ-013 SHALL clear pend_tran when addr_in_phase=1 and HREADYM=1; if new_tran=1 in the same cycle and addr_in_phase=0 it SHALL reload instead (load wins).
REQ-014 SHALL drive M-side outputs from the holding register when pend_tran=1, else directly (combinationally) from the S-side inputs.
REQ-015 SHALL, when presenting a held SEQ transfer, drive HTRANSM=NONSEQ and HBURSTM=INCR, because arbitration may have interleaved another master; held NONSEQ SHALL pass unchanged.
REQ-016 SHALL drive active_trans = pend_tran | new_tran.
REQ-017 SHALL drive HREADYOUTS = 0 while pend_tran=1; else HREADYM when data_in_phase=1; else 1.
REQ-018 SHALL drive HRESPS = HRESPM when data_in_phase=1, else OKAY (2'b00).
REQ-019 SHALL, on ERROR response (HRESPM=ERROR with HREADYM=0 during data_in_phase), discard a pending transfer on the following cycle if the master drives HTRANSS=IDLE with HREADYS=1.
REQ-020 SHALL hold HMASTLOCKM from the held copy while pending so the locked sequence is not broken by output re-arbitration.
REQ-021 SHALL hold zero-wait-state throughput: back-to-back accepted transfers with addr_in_phase=1, HREADYM=1 add no cycles.

Reset
REQ-022 SHALL on HRESETn=0 asynchronously clear pend_tran and all holding registers to 0 (HTRANS=IDLE).
REQ-023 SHALL output during reset HREADYOUTS=1, HRESPS=OKAY, active_trans=0, M-side outputs equal to S-side inputs.
REQ-024 SHALL, on reset mid-pending, drop the held transfer with no request issued after release.

Structure
REQ-025 SHALL take HTRANS (IDLE/BUSY/NONSEQ/SEQ), HBURST (SINGLE/INCR/…) and HRESP (OKAY/ERROR) encodings from the shared matrix package ahb_mtx_l1_pkg.
REQ-026 SHALL implement the holding register as one sub-module ahb_mtx_l1_in_hold (load/clear control, SEQ-to-NONSEQ rewrite).

Verification
REQ-027 Accepted immediately: NONSEQ addr 0x2000_0000, addr_in_phase=1, HREADYM=1 -> pend_tran stays 0, HREADYOUTS=1 next cycle, HADDRM passes through same cycle.
REQ-028 Blocked: NONSEQ 0x4000_0010 with addr_in_phase=0 for 3 cycles -> pend_tran=1, HREADYOUTS=0 for 3 cycles, HADDRM=0x4000_0010 held; grant -> released, HREADYOUTS follows HREADYM.
REQ-029 SEQ blocked mid INCR4 -> held beat presented HTRANSM=NONSEQ, HBURSTM=INCR, address unchanged.
REQ-030 Data phase wait: data_in_phase=1, HREADYM low 2 cycles, HRESPM=OKAY -> HREADYOUTS low 2 cycles, HRESPS=OKAY.
REQ-031 Two-cycle ERROR with pending transfer, master then drives IDLE -> HRESPS=ERROR both cycles, pend_tran cleared, active_trans=0.
REQ-032 HRESETn asserted while pend_tran=1 -> pend_tran=0, HREADYOUTS=1 immediately, no request after release.
